// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, decodes 11-bit frames with
// odd-parity/stop checks and a stall watchdog, then buffers good codes in a show-ahead FIFO.
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int HIST_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          CLOCK,
  input  logic                          rst_n,
  input  logic                          PS2_KBCLK,
  input  logic                          PS2_KBDAT,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [8*HIST_BYTES-1:0]       code_vector,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [1:0]                    dbg_state
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_fall;
  logic                   w_bit;

  state_t    r_state;
  state_t    w_state_next;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_par;
  logic [WD_W-1:0] r_wd_cnt;

  logic w_start;
  logic w_shift_en;
  logic w_latch_par;
  logic w_commit;
  logic w_par_bad;
  logic w_stop_bad;
  logic w_timeout;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_overflow;
  logic                r_parity_err;
  logic                r_frame_err;
  logic [8*HIST_BYTES-1:0] r_cv;
  logic [8*HIST_BYTES-1:0] w_cv_next;
  logic                w_full;
  logic                w_pop;
  logic                w_push;

  // Lines idle high, so the synchronisers reset to 1 to avoid a phantom fall.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], PS2_KBCLK};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], PS2_KBDAT};
      r_clk_prev <= w_clk_s;
    end
  end

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_bit   = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_clk_s;

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_shift_en   = 1'b0;
    w_latch_par  = 1'b0;
    w_commit     = 1'b0;
    w_par_bad    = 1'b0;
    w_stop_bad   = 1'b0;
    w_timeout    = 1'b0;
    if (r_state != S_IDLE && !w_fall && r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
      w_timeout    = 1'b1;
      w_state_next = S_IDLE;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          if (!w_bit) begin
            w_start      = 1'b1;
            w_state_next = S_DATA;
          end
        end
        S_DATA: begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_next = S_PARITY;
        end
        S_PARITY: begin
          w_latch_par  = 1'b1;
          w_state_next = S_STOP;
        end
        S_STOP: begin
          w_state_next = S_IDLE;
          // Parity is judged first so a doubly-corrupt frame reports only parity.
          if ((^r_shift ^ r_par) != 1'b1) w_par_bad  = 1'b1;
          else if (!w_bit)                w_stop_bad = 1'b1;
          else                            w_commit   = 1'b1;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_wd_cnt     <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_start) r_bit_cnt <= '0;
      else if (w_shift_en) begin
        r_shift[r_bit_cnt] <= w_bit;
        r_bit_cnt          <= r_bit_cnt + 3'd1;
      end
      if (w_latch_par) r_par <= w_bit;
      if (r_state == S_IDLE || w_fall) r_wd_cnt <= '0;
      else                             r_wd_cnt <= r_wd_cnt + 1'b1;
      r_parity_err <= w_par_bad;
      r_frame_err  <= w_stop_bad | w_timeout;
    end
  end

  generate
    if (HIST_BYTES == 1) begin : g_hist_one
      assign w_cv_next = r_shift;
    end else begin : g_hist_many
      assign w_cv_next = {r_cv[8*HIST_BYTES-9:0], r_shift};
    end
  endgenerate

  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop  = rd_en && (r_count != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push = w_commit && (!w_full || w_pop);

  always_ff @(posedge CLOCK) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_cv       <= '0;
    end else begin
      if (w_commit) r_cv <= w_cv_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_commit && w_full && !w_pop) r_overflow <= 1'b1;
      else if (clr_err)                 r_overflow <= 1'b0;
    end
  end

  assign rd_valid    = (r_count != '0);
  assign rd_data     = rd_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign fifo_count  = r_count;
  assign code_vector = r_cv;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign overflow    = r_overflow;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames bit by bit and checks FIFO,
// history, error pulses and watchdog behaviour against hand-derived values.
module tb_ps2_rx_fifo;

  localparam int SYNC_STAGES    = 2;
  localparam int FIFO_DEPTH     = 4;
  localparam int HIST_BYTES     = 2;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int HALF           = 10;

  logic        CLOCK = 1'b0;
  logic        rst_n = 1'b0;
  logic        PS2_KBCLK = 1'b1;
  logic        PS2_KBDAT = 1'b1;
  logic        rd_en = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [2:0]  fifo_count;
  logic [15:0] code_vector;
  logic        parity_err;
  logic        frame_err;
  logic        overflow;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int par_pulses = 0;
  int frm_pulses = 0;

  ps2_rx_fifo #(
    .SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH),
    .HIST_BYTES(HIST_BYTES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLOCK(CLOCK), .rst_n(rst_n), .PS2_KBCLK(PS2_KBCLK), .PS2_KBDAT(PS2_KBDAT),
    .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .code_vector(code_vector), .parity_err(parity_err),
    .frame_err(frame_err), .overflow(overflow), .dbg_state(dbg_state)
  );

  // Clock/reset
  always #5 CLOCK = ~CLOCK;

  // Counts high cycles of each error strobe; a one-cycle pulse adds exactly one.
  always @(negedge CLOCK) begin
    if (parity_err === 1'b1) par_pulses++;
    if (frame_err === 1'b1)  frm_pulses++;
  end

  // Driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic ps2_bit(input logic b);
    PS2_KBDAT = b;
    wait_cycles(HALF);
    PS2_KBCLK = 1'b0;
    wait_cycles(HALF);
    PS2_KBCLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(stop);
    PS2_KBDAT = 1'b1;
    wait_cycles(3 * HALF);
  endtask

  task automatic pop;
    @(negedge CLOCK) rd_en = 1'b1;
    @(negedge CLOCK) rd_en = 1'b0;
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    wait_cycles(3);
    n_checks++; if (rd_valid !== 1'b0)       begin n_fail++; $display("FAIL reset_rd_valid got %h exp 0", rd_valid); end
    n_checks++; if (fifo_count !== 3'd0)     begin n_fail++; $display("FAIL reset_count got %h exp 0", fifo_count); end
    n_checks++; if (rd_data !== 8'h00)       begin n_fail++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
    n_checks++; if (code_vector !== 16'h0)   begin n_fail++; $display("FAIL reset_cv got %h exp 0000", code_vector); end
    n_checks++; if ({parity_err, frame_err, overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {parity_err, frame_err, overflow}); end
    n_checks++; if (dbg_state !== 2'd0)      begin n_fail++; $display("FAIL reset_state got %h exp 0", dbg_state); end
    rst_n = 1'b1;
    wait_cycles(5);
  endtask

  task automatic test_single;
    send_frame(8'h1C, 1'b0, 1'b1);
    n_checks++; if (rd_valid !== 1'b1)        begin n_fail++; $display("FAIL single_valid got %h exp 1", rd_valid); end
    n_checks++; if (rd_data !== 8'h1C)        begin n_fail++; $display("FAIL single_data got %h exp 1c", rd_data); end
    n_checks++; if (fifo_count !== 3'd1)      begin n_fail++; $display("FAIL single_count got %h exp 1", fifo_count); end
    n_checks++; if (code_vector !== 16'h001C) begin n_fail++; $display("FAIL single_cv got %h exp 001c", code_vector); end
    n_checks++; if (par_pulses + frm_pulses !== 0) begin n_fail++; $display("FAIL single_no_err got %0d exp 0", par_pulses + frm_pulses); end
    pop();
    n_checks++; if (fifo_count !== 3'd0)      begin n_fail++; $display("FAIL single_pop_count got %h exp 0", fifo_count); end
  endtask

  task automatic test_two_frames;
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    n_checks++; if (code_vector !== 16'hF01C) begin n_fail++; $display("FAIL two_cv got %h exp f01c", code_vector); end
    n_checks++; if (fifo_count !== 3'd2)      begin n_fail++; $display("FAIL two_count got %h exp 2", fifo_count); end
    n_checks++; if (rd_data !== 8'hF0)        begin n_fail++; $display("FAIL two_head1 got %h exp f0", rd_data); end
    pop();
    n_checks++; if (rd_data !== 8'h1C)        begin n_fail++; $display("FAIL two_head2 got %h exp 1c", rd_data); end
    pop();
    n_checks++; if (rd_valid !== 1'b0)        begin n_fail++; $display("FAIL two_empty got %h exp 0", rd_valid); end
  endtask

  task automatic test_errors;
    send_frame(8'h5A, 1'b0, 1'b1);
    n_checks++; if (par_pulses !== 1)         begin n_fail++; $display("FAIL parity_pulse got %0d exp 1", par_pulses); end
    n_checks++; if (fifo_count !== 3'd0)      begin n_fail++; $display("FAIL parity_nocommit got %h exp 0", fifo_count); end
    n_checks++; if (code_vector !== 16'hF01C) begin n_fail++; $display("FAIL parity_cv got %h exp f01c", code_vector); end
    send_frame(8'h5A, 1'b1, 1'b1);
    n_checks++; if (rd_data !== 8'h5A || fifo_count !== 3'd1) begin n_fail++; $display("FAIL parity_recover got %h/%h exp 5a/1", rd_data, fifo_count); end
    n_checks++; if (code_vector !== 16'h1C5A) begin n_fail++; $display("FAIL parity_recover_cv got %h exp 1c5a", code_vector); end
    pop();
    send_frame(8'h12, 1'b1, 1'b0);
    n_checks++; if (frm_pulses !== 1 || par_pulses !== 1) begin n_fail++; $display("FAIL stop_pulse got frm %0d par %0d exp 1/1", frm_pulses, par_pulses); end
    n_checks++; if (fifo_count !== 3'd0)      begin n_fail++; $display("FAIL stop_nocommit got %h exp 0", fifo_count); end
    send_frame(8'h12, 1'b0, 1'b0);
    n_checks++; if (par_pulses !== 2 || frm_pulses !== 1) begin n_fail++; $display("FAIL both_bad got par %0d frm %0d exp 2/1", par_pulses, frm_pulses); end
  endtask

  task automatic test_timeout;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    PS2_KBDAT = 1'b1;
    wait_cycles(5);
    n_checks++; if (dbg_state !== 2'd1)       begin n_fail++; $display("FAIL stall_in_data got %h exp 1", dbg_state); end
    wait_cycles(TIMEOUT_CYCLES + 20);
    n_checks++; if (frm_pulses !== 2)         begin n_fail++; $display("FAIL timeout_pulse got %0d exp 2", frm_pulses); end
    n_checks++; if (dbg_state !== 2'd0)       begin n_fail++; $display("FAIL timeout_idle got %h exp 0", dbg_state); end
    n_checks++; if (rd_valid !== 1'b0)        begin n_fail++; $display("FAIL timeout_nocommit got %h exp 0", rd_valid); end
    send_frame(8'h29, 1'b0, 1'b1);
    n_checks++; if (rd_data !== 8'h29 || code_vector !== 16'h5A29) begin n_fail++; $display("FAIL timeout_next got %h/%h exp 29/5a29", rd_data, code_vector); end
    pop();
  endtask

  task automatic test_overflow;
    logic [7:0] b;
    for (int i = 1; i <= FIFO_DEPTH + 1; i++) begin
      b = 8'(i);
      send_frame(b, odd_par(b), 1'b1);
    end
    n_checks++; if (fifo_count !== 3'd4)      begin n_fail++; $display("FAIL ovf_count got %h exp 4", fifo_count); end
    n_checks++; if (overflow !== 1'b1)        begin n_fail++; $display("FAIL ovf_flag got %h exp 1", overflow); end
    n_checks++; if (rd_data !== 8'h01)        begin n_fail++; $display("FAIL ovf_head got %h exp 01", rd_data); end
    n_checks++; if (code_vector !== 16'h0405) begin n_fail++; $display("FAIL ovf_cv got %h exp 0405", code_vector); end
    @(negedge CLOCK) clr_err = 1'b1;
    @(negedge CLOCK) clr_err = 1'b0;
    n_checks++; if (overflow !== 1'b0)        begin n_fail++; $display("FAIL ovf_clear got %h exp 0", overflow); end
    for (int i = 1; i <= FIFO_DEPTH; i++) begin
      b = 8'(i);
      n_checks++; if (rd_data !== b)          begin n_fail++; $display("FAIL ovf_drain got %h exp %h", rd_data, b); end
      pop();
    end
    n_checks++; if (rd_valid !== 1'b0)        begin n_fail++; $display("FAIL ovf_empty got %h exp 0", rd_valid); end
  endtask

  task automatic test_reset_mid_frame;
    send_frame(8'hAA, odd_par(8'hAA), 1'b1);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    @(negedge CLOCK) rst_n = 1'b0;
    wait_cycles(2);
    n_checks++; if ({rd_valid, fifo_count, rd_data, code_vector} !== 28'h0) begin n_fail++; $display("FAIL midrst_outputs got %h/%h/%h/%h exp 0", rd_valid, fifo_count, rd_data, code_vector); end
    n_checks++; if ({dbg_state, overflow} !== 3'b000) begin n_fail++; $display("FAIL midrst_state got %h/%h exp 0/0", dbg_state, overflow); end
    PS2_KBDAT = 1'b1;
    rst_n = 1'b1;
    wait_cycles(10);
    send_frame(8'h1C, 1'b0, 1'b1);
    n_checks++; if (rd_data !== 8'h1C || fifo_count !== 3'd1) begin n_fail++; $display("FAIL midrst_frame got %h/%h exp 1c/1", rd_data, fifo_count); end
    n_checks++; if (code_vector !== 16'h001C) begin n_fail++; $display("FAIL midrst_cv got %h exp 001c", code_vector); end
    n_checks++; if (par_pulses !== 2 || frm_pulses !== 2) begin n_fail++; $display("FAIL midrst_errs got %0d/%0d exp 2/2", par_pulses, frm_pulses); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_frames();
    test_errors();
    test_timeout();
    test_overflow();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver: oversamples PS2_KBCLK/PS2_KBDAT in the CLOCK domain, decodes 11-bit device-to-host frames, and checks odd parity and the stop bit. It recovers from stalled frames via a watchdog, buffers good scan codes in a show-ahead FIFO, and keeps a shift history of the last HIST_BYTES codes. It sits between the keyboard pins and the scan-code decoder. It is the successor to the single-register 16-bit code_vector receiver.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer flops per PS/2 line (≥2)
- FIFO_DEPTH, 8, scan-code FIFO entries (power of 2, ≥2)
- HIST_BYTES, 2, bytes kept in code_vector (≥1)
- TIMEOUT_CYCLES, 50000, CLOCK cycles allowed between PS/2 falling edges inside a frame

Ports:
- CLOCK  in  1  system clock, all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- PS2_KBCLK  in  1  PS/2 clock, asynchronous
- PS2_KBDAT  in  1  PS/2 data, asynchronous
- rd_en  in  1  pop FIFO head (ignored when empty)
- clr_err  in  1  clears sticky overflow
- rd_data  out  8  FIFO head byte (valid when rd_valid)
- rd_valid  out  1  FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- code_vector  out  8*HIST_BYTES  history; newest byte in [7:0]
- parity_err  out  1  one-cycle pulse, bad parity
- frame_err  out  1  one-cycle pulse, bad stop bit or timeout
- overflow  out  1  sticky, byte dropped because FIFO full

## Operation
- Both lines pass through SYNC_STAGES flops that reset to 1. The fall pulse is synced clk prev=1, now=0, and lasts one cycle. The data bit is the synced data in that cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: fall with data=0 → DATA, bit_cnt=0. Fall with data=1 is ignored.
  - DATA: shift_reg[bit_cnt]←data (LSB first), bit_cnt++. On the 8th bit → PARITY.
  - PARITY: latch parity bit → STOP.
  - STOP: go to IDLE. Then:
    - If ^byte ^ parity == 1 and data == 1: commit.
    - If parity is bad: parity_err pulse, no commit. This takes priority over a bad stop bit.
    - Else, if stop bit = 0: frame_err pulse, no commit.
- Commit:
  - code_vector ← {code_vector[8*HIST_BYTES-9:0], byte}. With HIST_BYTES=1, code_vector ← byte.
  - Push the byte to the FIFO.
- Watchdog: the counter clears on every fall and counts while not in IDLE. On reaching TIMEOUT_CYCLES: frame_err pulse, → IDLE, partial byte discarded, no commit. The counter is held at 0 in IDLE.
- FIFO is show-ahead: rd_data = head.
  - rd_en && rd_valid pops.
  - Push when full without a same-cycle pop: byte dropped, overflow←1. code_vector is still updated.
  - Push and pop in the same cycle, including when full: both happen, count unchanged, no overflow.
  - Push into an empty FIFO: rd_valid rises at the commit edge.
- Pointers wrap modulo FIFO_DEPTH. The count distinguishes full from empty.
- clr_err clears overflow. If an overflow event occurs in the same cycle, the set wins.

## Timing
- Reset values: state IDLE, all counters 0, FIFO empty.
  - rd_valid=0, fifo_count=0, rd_data=0, code_vector=0.
  - parity_err=0, frame_err=0, overflow=0.
- Pin fall to fall pulse: SYNC_STAGES+1 CLOCK cycles.
- Stop-bit fall pulse in cycle t: the following all update at the end of t and are visible at t+1:
  - commit, or error pulse
  - code_vector
  - fifo_count
  - rd_valid
- Pop: fifo_count and rd_data update the edge after rd_en sampled high.
- Error pulses are exactly one cycle. Back-to-back frames need no gap beyond the PS/2 line idle.
- rst_n low mid-frame: immediate return to the reset values. The first frame after release must start with a fresh start bit.
- Minimum PS/2 clock low/high time accepted: SYNC_STAGES+2 CLOCK cycles.

## Test plan
- Frame 0x1C, parity=0, stop=1 → rd_valid=1, rd_data=0x1C, fifo_count=1, code_vector=0x001C. No error pulse.
- Frames 0xF0 (p=1) then 0x1C (p=0) → code_vector=0xF01C. Two pops return 0xF0 then 0x1C. rd_valid=0 after the second pop.
- Frame 0x5A sent with parity bit 0 → one parity_err pulse, FIFO empty, code_vector unchanged. A following good 0x5A (p=1) is accepted.
- Start bit plus 4 data bits, then the line stalls for TIMEOUT_CYCLES → frame_err pulse, FSM back in IDLE. A next good frame 0x29 (p=0) is received correctly.
- FIFO_DEPTH+1 good frames with no reads → fifo_count=FIFO_DEPTH, overflow=1, head is the first byte, code_vector holds the last bytes. clr_err → overflow=0.
- rst_n asserted after 3 data bits → all outputs 0. A full 0x1C frame after release is received intact.
